// File: rtl/zeroheti_pkg.sv
// zeroheti_pkg: shared address map, interrupt controller register offsets and CLAIM field layout
package zeroheti_pkg;

   typedef struct packed {
      logic [31:0] base;
      logic [31:0] last;
   } addr_rule_t;

   typedef struct packed {
      addr_rule_t hetic;
   } addr_map_t;

   localparam addr_map_t AddrMap = '{hetic: '{base: 32'h0003_0000, last: 32'h0003_0fff}};

   localparam logic [2:0] OffPending = 3'd0;
   localparam logic [2:0] OffEnable  = 3'd1;
   localparam logic [2:0] OffEdge    = 3'd2;
   localparam logic [2:0] OffClaim   = 3'd3;
   localparam logic [2:0] OffPrio    = 3'd4;

   localparam int ClaimValidBit = 31;
   localparam int ClaimPrioLsb  = 8;
   localparam int ClaimIdLsb    = 0;

   localparam int NrIrqsDefault = 8;
   localparam int IrqIdWidth    = $clog2(NrIrqsDefault);

endpackage

// File: rtl/irq_prio_arb.sv
// irq_prio_arb: combinational winner select, highest nonzero priority, ties to lowest index
module irq_prio_arb #(
   parameter int NrIrqs    = 8,
   parameter int PrioWidth = 4
) (
   input  logic [NrIrqs-1:0]           req_i,
   input  logic [NrIrqs*PrioWidth-1:0] prio_i,
   output logic                        valid_o,
   output logic [$clog2(NrIrqs)-1:0]   id_o,
   output logic [PrioWidth-1:0]        prio_o
);
   localparam int IdW = $clog2(NrIrqs);

   // strict compare keeps the lowest index on ties; prio 0 never beats the zero seed
   always_comb begin
      id_o   = '0;
      prio_o = '0;
      for (int i = 0; i < NrIrqs; i++) begin
         if (req_i[i] && prio_i[i*PrioWidth +: PrioWidth] > prio_o) begin
            id_o   = IdW'(i);
            prio_o = prio_i[i*PrioWidth +: PrioWidth];
         end
      end
   end

   assign valid_o = prio_o != '0;

endmodule

// File: rtl/apb_irq_ctrl.sv
// apb_irq_ctrl: APB-programmable interrupt controller with edge/level sources
// and a registered highest-priority request towards the core
module apb_irq_ctrl
   import zeroheti_pkg::*;
#(
   parameter int NrIrqs    = 8,
   parameter int PrioWidth = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      psel_i,
   input  logic                      penable_i,
   input  logic                      pwrite_i,
   input  logic [31:0]               paddr_i,
   input  logic [31:0]               pwdata_i,
   output logic [31:0]               prdata_o,
   output logic                      pready_o,
   output logic                      pslverr_o,
   input  logic [NrIrqs-1:0]         irq_src_i,
   output logic                      irq_valid_o,
   output logic [$clog2(NrIrqs)-1:0] irq_id_o,
   output logic [PrioWidth-1:0]      irq_prio_o
);
   localparam int IdW = $clog2(NrIrqs);
   localparam int PW  = NrIrqs * PrioWidth;

   logic [NrIrqs-1:0] src_q, pend_q, en_q, edge_q, edge_d, pend, pend_d, rise, w1c, claim_clr;
   logic [PW-1:0] prio_q;
   logic [2:0] off;
   logic acc, wr, rd, arb_valid;
   logic [IdW-1:0] arb_id;
   logic [PrioWidth-1:0] arb_prio;
   logic [31:0] claim_word, rdata;
   logic unused_bits;

   assign off = paddr_i[4:2];
   assign acc = psel_i & penable_i;
   assign wr  = acc & pwrite_i;
   assign rd  = acc & ~pwrite_i;

   // level sources mirror the sampled input; only edge sources hold state in pend_q
   assign pend      = (edge_q & pend_q) | (~edge_q & src_q);
   assign rise      = irq_src_i & ~src_q;
   assign w1c       = (wr && off == OffPending) ? pwdata_i[NrIrqs-1:0] : '0;
   assign claim_clr = (rd && off == OffClaim && irq_valid_o) ? NrIrqs'(1) << irq_id_o : '0;
   assign edge_d    = (wr && off == OffEdge) ? pwdata_i[NrIrqs-1:0] : edge_q;
   // set beats clear; an EDGE change (or level mode) drops the stored bit
   assign pend_d    = ((pend_q & ~(w1c | claim_clr)) | rise) & edge_q & edge_d;

   irq_prio_arb #(
      .NrIrqs   (NrIrqs),
      .PrioWidth(PrioWidth)
   ) u_arb (
      .req_i  (pend & en_q),
      .prio_i (prio_q),
      .valid_o(arb_valid),
      .id_o   (arb_id),
      .prio_o (arb_prio)
   );

   always_comb begin
      claim_word                         = '0;
      claim_word[ClaimValidBit]          = irq_valid_o;
      claim_word[ClaimPrioLsb +: 8]      = 8'(irq_prio_o);
      claim_word[ClaimIdLsb +: 8]        = 8'(irq_id_o);
      rdata = off == OffPending ? 32'(pend) :
              off == OffEnable  ? 32'(en_q) :
              off == OffEdge    ? 32'(edge_q) :
              off == OffClaim   ? claim_word :
              off == OffPrio    ? 32'(prio_q) : '0;
   end

   assign prdata_o    = (rd && !rst_i) ? rdata : '0;
   assign pslverr_o   = acc && !rst_i && (off > OffPrio || (off == OffClaim && pwrite_i));
   assign pready_o    = 1'b1;
   assign unused_bits = ^{paddr_i, pwdata_i};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         src_q       <= '0;
         pend_q      <= '0;
         en_q        <= '0;
         edge_q      <= '0;
         prio_q      <= '0;
         irq_valid_o <= 1'b0;
         irq_id_o    <= '0;
         irq_prio_o  <= '0;
      end else begin
         src_q       <= irq_src_i;
         pend_q      <= pend_d;
         edge_q      <= edge_d;
         if (wr && off == OffEnable) en_q <= pwdata_i[NrIrqs-1:0];
         if (wr && off == OffPrio) prio_q <= PW'(pwdata_i);
         irq_valid_o <= arb_valid;
         irq_id_o    <= arb_id;
         irq_prio_o  <= arb_prio;
      end
   end

endmodule

// File: tb/tb_apb_irq_ctrl.sv
// tb_apb_irq_ctrl: directed scenarios plus random APB/source traffic against a per-source behavioural model
module tb_apb_irq_ctrl;
   localparam int N = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [31:0] paddr = '0, pwdata = '0, prdata;
   logic pready, pslverr;
   logic [N-1:0] src = '0;
   logic irq_valid;
   logic [2:0] irq_id;
   logic [3:0] irq_prio;
   bit rand_src = 1'b0;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   apb_irq_ctrl #(.NrIrqs(N), .PrioWidth(4)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .psel_i     (psel),
      .penable_i  (penable),
      .pwrite_i   (pwrite),
      .paddr_i    (paddr),
      .pwdata_i   (pwdata),
      .prdata_o   (prdata),
      .pready_o   (pready),
      .pslverr_o  (pslverr),
      .irq_src_i  (src),
      .irq_valid_o(irq_valid),
      .irq_id_o   (irq_id),
      .irq_prio_o (irq_prio)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // model: per-source arrays, pending for level sources is the sampled input
   bit m_prev[N], m_pend[N], m_en[N], m_edge[N];
   int m_prio[N];
   bit m_valid;
   int m_id, m_pr;

   function automatic bit eff(input int i);
      return m_edge[i] ? m_pend[i] : m_prev[i];
   endfunction

   function automatic logic [31:0] m_read(input logic [2:0] off);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < N; i++) begin
         if (off == 3'd0) r[i] = eff(i);
         if (off == 3'd1) r[i] = m_en[i];
         if (off == 3'd2) r[i] = m_edge[i];
         if (off == 3'd4) r[i*4 +: 4] = 4'(m_prio[i]);
      end
      if (off == 3'd3) r = {m_valid, 15'b0, 8'(m_pr), 8'(m_id)};
      return r;
   endfunction

   task automatic step();
      int best, bid;
      bit acc, wr, rd, clr, rise, nedge;
      logic [2:0] off;
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            m_prev[i] = 0; m_pend[i] = 0; m_en[i] = 0; m_edge[i] = 0; m_prio[i] = 0;
         end
         m_valid = 0; m_id = 0; m_pr = 0;
         return;
      end
      best = 0;
      bid = 0;
      for (int i = 0; i < N; i++)
         if (eff(i) && m_en[i] && m_prio[i] > best) begin
            best = m_prio[i];
            bid = i;
         end
      acc = psel && penable;
      wr = acc && pwrite;
      rd = acc && !pwrite;
      off = paddr[4:2];
      for (int i = 0; i < N; i++) begin
         clr = (wr && off == 3'd0 && pwdata[i]) || (rd && off == 3'd3 && m_valid && m_id == i);
         rise = src[i] && !m_prev[i];
         nedge = (wr && off == 3'd2) ? pwdata[i] : m_edge[i];
         m_pend[i] = (nedge && m_edge[i]) ? (rise || (m_pend[i] && !clr)) : 1'b0;
         m_edge[i] = nedge;
         if (wr && off == 3'd1) m_en[i] = pwdata[i];
         if (wr && off == 3'd4) m_prio[i] = int'(pwdata[i*4 +: 4]);
         m_prev[i] = src[i];
      end
      m_valid = best != 0;
      m_id = bid;
      m_pr = best;
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      step();
   end

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         check("irq_valid", 32'(irq_valid), 32'(m_valid));
         check("irq_id", 32'(irq_id), 32'(m_id));
         check("irq_prio", 32'(irq_prio), 32'(m_pr));
      end
   end

   initial forever begin
      @(negedge clk);
      if (rand_src) src = src ^ N'($urandom & $urandom);
   end

   task automatic apb(input bit w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rdat, output logic err);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
      @(negedge clk);
      penable = 1'b1;
      #2;
      check("pready", 32'(pready), 32'd1);
      if (!w) check("prdata", prdata, m_read(a[4:2]));
      check("pslverr", 32'(pslverr), 32'(a[4:2] > 3'd4 || (a[4:2] == 3'd3 && w)));
      rdat = prdata;
      err = pslverr;
      @(posedge clk);
      #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   logic [31:0] rdat;
   logic err;
   int off;
   bit w;
   logic [31:0] d;

   initial begin
      psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h18;
      #12;
      check("rst_pslverr", 32'(pslverr), 32'd0);
      check("rst_prdata", prdata, 32'd0);
      check("rst_pready", 32'(pready), 32'd1);
      check("rst_valid", 32'(irq_valid), 32'd0);
      psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      apb(1, 32'h4, 32'h80, rdat, err);
      apb(1, 32'h10, 32'h3000_0000, rdat, err);
      apb(1, 32'h8, 32'h80, rdat, err);
      @(negedge clk) src[7] = 1'b1;
      @(negedge clk);
      check("edge_early_valid", 32'(irq_valid), 32'd0);
      src[7] = 1'b0;
      @(negedge clk);
      check("edge_valid", 32'(irq_valid), 32'd1);
      check("edge_id", 32'(irq_id), 32'd7);
      check("edge_prio", 32'(irq_prio), 32'd3);
      apb(0, 32'hC, 32'h0, rdat, err);
      check("claim_word", rdat, 32'h8000_0307);
      @(negedge clk);
      check("claim_valid_n1", 32'(irq_valid), 32'd1);
      @(negedge clk);
      check("claim_valid_n2", 32'(irq_valid), 32'd0);

      apb(1, 32'h8, 32'h24, rdat, err);
      apb(1, 32'h4, 32'h24, rdat, err);
      apb(1, 32'h10, 32'h0040_0400, rdat, err);
      @(negedge clk) src = 8'h24;
      @(negedge clk) src = 8'h00;
      @(negedge clk);
      check("tie_id", 32'(irq_id), 32'd2);
      check("tie_prio", 32'(irq_prio), 32'd4);
      apb(1, 32'h10, 32'h0060_0400, rdat, err);
      @(negedge clk);
      check("reprio_old_id", 32'(irq_id), 32'd2);
      @(negedge clk);
      check("reprio_id", 32'(irq_id), 32'd5);
      check("reprio_prio", 32'(irq_prio), 32'd6);
      apb(1, 32'h0, 32'h24, rdat, err);

      apb(1, 32'h8, 32'h0, rdat, err);
      apb(1, 32'h4, 32'h02, rdat, err);
      apb(1, 32'h10, 32'h10, rdat, err);
      @(negedge clk) src[1] = 1'b1;
      repeat (2) @(negedge clk);
      check("level_valid", 32'(irq_valid), 32'd1);
      check("level_id", 32'(irq_id), 32'd1);
      apb(1, 32'h0, 32'h2, rdat, err);
      apb(0, 32'h0, 32'h0, rdat, err);
      check("level_w1c_pending", rdat, 32'h2);
      @(negedge clk) src[1] = 1'b0;
      repeat (2) @(negedge clk);
      check("level_drop_valid", 32'(irq_valid), 32'd0);

      apb(1, 32'h8, 32'h08, rdat, err);
      apb(1, 32'h4, 32'h08, rdat, err);
      apb(1, 32'h10, 32'h1000, rdat, err);
      @(negedge clk) src[3] = 1'b1;
      @(negedge clk) src[3] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h8;
      @(negedge clk);
      penable = 1'b1;
      src[3] = 1'b1;
      @(posedge clk);
      #1;
      psel = 1'b0; penable = 1'b0;
      @(negedge clk) src[3] = 1'b0;
      apb(0, 32'h0, 32'h0, rdat, err);
      check("set_beats_w1c", rdat, 32'h8);
      apb(1, 32'h0, 32'h8, rdat, err);
      apb(0, 32'h0, 32'h0, rdat, err);
      check("w1c_clears", rdat, 32'h0);

      apb(0, 32'h18, 32'h0, rdat, err);
      check("unmapped_rdata", rdat, 32'h0);
      check("unmapped_err", 32'(err), 32'd1);
      apb(1, 32'hC, 32'hFFFF_FFFF, rdat, err);
      check("claim_write_err", 32'(err), 32'd1);
      apb(0, 32'h4, 32'h0, rdat, err);
      check("enable_kept", rdat, 32'h08);

      rand_src = 1'b1;
      for (int k = 0; k < 400; k++) begin
         off = $urandom_range(0, 7);
         w = 1'($urandom_range(0, 1));
         d = $urandom;
         apb(w, {27'b0, 3'(off), 2'b0}, d, rdat, err);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      rand_src = 1'b0;
      @(negedge clk) src = '0;

      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'hC;
      @(negedge clk);
      penable = 1'b1;
      #2 rst = 1'b1;
      #1;
      check("midrst_prdata", prdata, 32'd0);
      check("midrst_pslverr", 32'(pslverr), 32'd0);
      check("midrst_pready", 32'(pready), 32'd1);
      check("midrst_valid", 32'(irq_valid), 32'd0);
      check("midrst_prio", 32'(irq_prio), 32'd0);
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int a = 0; a < 5; a++) begin
         apb(0, 32'(a * 4), 32'h0, rdat, err);
         check("post_rst_reg", rdat, 32'h0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
